// File: rtl/gpr_writeback_arbiter.sv
// gpr_writeback_arbiter
//   Writeback stage in front of the 64-bit x 32-entry GPR file. It picks one
//   ALU or LSU result per cycle for the single register-file write port. It
//   also keeps the busy scoreboard that the issue stage uses to stall on
//   pending destination registers.
//
// Ports
//   clk, rst                    clock; synchronous active-high reset
//   alu_vld/alu_rd/alu_data     ALU result in;  alu_rdy = accepted this cycle
//   lsu_vld/lsu_rd/lsu_data     load result in; lsu_rdy = accepted this cycle
//   iss_vld/iss_rd              issue of a register-writing instruction
//   busy_vec                    per-register write-pending bits (bit 0 always 0)
//   wb_en/rd0_addr/rd0_data     registered write port (wb_en -> file clk_en)
module gpr_writeback_arbiter #(
    parameter int XLEN       = 64,
    parameter int STARVE_MAX = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_vld,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_rdy,
    input  logic            lsu_vld,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_rdy,
    input  logic            iss_vld,
    input  logic [4:0]      iss_rd,
    output logic [31:0]     busy_vec,
    output logic            wb_en,
    output logic [4:0]      rd0_addr,
    output logic [XLEN-1:0] rd0_data
);

    localparam logic [2:0] SMAX = 3'(STARVE_MAX);

    logic [2:0]  starve_cnt;
    logic        force_alu;
    logic        alu_acc;
    logic        lsu_acc;
    logic [31:0] busy_nxt;

    // LSU wins by default; once the ALU has stalled SMAX cycles in a row it
    // takes the port, and the LSU is held off for that one cycle.
    assign force_alu = (starve_cnt == SMAX) && alu_vld;
    assign lsu_rdy   = !rst && !force_alu;
    assign alu_rdy   = !rst && (!lsu_vld || force_alu);

    // The ready terms are mutually exclusive whenever both valids are high,
    // so at most one of these is set.
    assign alu_acc = alu_vld && alu_rdy;
    assign lsu_acc = lsu_vld && lsu_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 3'd0;
        end else if (alu_vld && !alu_rdy) begin
            if (starve_cnt != SMAX)
                starve_cnt <= starve_cnt + 3'd1;
        end else begin
            starve_cnt <= 3'd0;
        end
    end

    // Results to x0 are still accepted, but they never assert wb_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en    <= 1'b0;
            rd0_addr <= 5'd0;
            rd0_data <= '0;
        end else if (alu_acc) begin
            wb_en    <= (alu_rd != 5'd0);
            rd0_addr <= alu_rd;
            rd0_data <= alu_data;
        end else if (lsu_acc) begin
            wb_en    <= (lsu_rd != 5'd0);
            rd0_addr <= lsu_rd;
            rd0_data <= lsu_data;
        end else begin
            wb_en    <= 1'b0;
        end
    end

    // The clear is applied before the set, so a new issue to a register that
    // is being written back in the same cycle keeps its busy bit.
    always_comb begin
        busy_nxt = busy_vec;
        if (wb_en)
            busy_nxt[rd0_addr] = 1'b0;
        if (iss_vld && (iss_rd != 5'd0))
            busy_nxt[iss_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy_vec <= 32'd0;
        else
            busy_vec <= busy_nxt;
    end

endmodule

// File: tb/tb_gpr_writeback_arbiter.sv
module tb_gpr_writeback_arbiter;
    localparam int XLEN = 64;
    localparam int SM   = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_vld, lsu_vld, iss_vld;
    logic [4:0]      alu_rd, lsu_rd, iss_rd;
    logic [XLEN-1:0] alu_data, lsu_data;
    logic            alu_rdy, lsu_rdy, wb_en;
    logic [31:0]     busy_vec;
    logic [4:0]      rd0_addr;
    logic [XLEN-1:0] rd0_data;

    int n_pass = 0;
    int n_total = 0;

    // Reference state: how many cycles the ALU has waited, the pending write
    // and the set of registers with writes outstanding.
    int              m_wait;
    logic            m_wb;
    logic [4:0]      m_addr;
    logic [XLEN-1:0] m_data;
    logic [31:0]     m_busy;

    always #5 clk = ~clk;

    gpr_writeback_arbiter #(.XLEN(XLEN), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .alu_vld(alu_vld), .alu_rd(alu_rd), .alu_data(alu_data), .alu_rdy(alu_rdy),
        .lsu_vld(lsu_vld), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_rdy(lsu_rdy),
        .iss_vld(iss_vld), .iss_rd(iss_rd), .busy_vec(busy_vec),
        .wb_en(wb_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data)
    );

    function automatic logic [1:0] model_ready();
        bit starving;
        starving = alu_vld && (m_wait >= SM);
        if (rst) return 2'b00;
        return {(!lsu_vld || starving), !starving};   // {alu_rdy, lsu_rdy}
    endfunction

    function automatic void model_edge();
        bit starving, take_l, take_a;
        if (rst) begin
            m_wait = 0; m_wb = 0; m_addr = 0; m_data = 0; m_busy = 0;
            return;
        end
        starving = alu_vld && (m_wait >= SM);
        take_l   = lsu_vld && !starving;
        take_a   = alu_vld && !take_l;
        if (m_wb) m_busy[m_addr] = 1'b0;
        if (iss_vld && iss_rd != 0) m_busy[iss_rd] = 1'b1;
        if (alu_vld && !take_a) m_wait = (m_wait + 1 > SM) ? SM : m_wait + 1;
        else m_wait = 0;
        if (take_l) begin
            m_wb = (lsu_rd != 0); m_addr = lsu_rd; m_data = lsu_data;
        end else if (take_a) begin
            m_wb = (alu_rd != 0); m_addr = alu_rd; m_data = alu_data;
        end else begin
            m_wb = 1'b0;
        end
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_vld = 0; lsu_vld = 0; iss_vld = 0;
        alu_rd = 0; lsu_rd = 0; iss_rd = 0; alu_data = 0; lsu_data = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1; alu_vld = 1; lsu_vld = 1; iss_vld = 1;
        alu_rd = 2; lsu_rd = 3; iss_rd = 4;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_total++;
            if ({alu_rdy, lsu_rdy} !== 2'b00)
                $display("FAIL reset_ready cyc%0d got=%b exp=00", i, {alu_rdy, lsu_rdy});
            else n_pass++;
            tick();
            n_total++;
            if ({wb_en, rd0_addr, rd0_data, busy_vec} !== 102'd0)
                $display("FAIL reset_outputs cyc%0d wb=%b addr=%0d data=%h busy=%h exp all 0",
                         i, wb_en, rd0_addr, rd0_data, busy_vec);
            else n_pass++;
        end
        rst = 0;
        idle();
        tick();
    endtask

    task automatic test_single_alu();
        alu_vld = 1; alu_rd = 5; alu_data = 64'hDEAD_BEEF_0000_0001;
        #1;
        n_total++;
        if (alu_rdy !== 1'b1) $display("FAIL single_alu_rdy got=%b exp=1", alu_rdy);
        else n_pass++;
        tick();
        alu_vld = 0;
        n_total++;
        if ({wb_en, rd0_addr, rd0_data} !== {1'b1, 5'd5, 64'hDEAD_BEEF_0000_0001})
            $display("FAIL single_alu_write wb=%b addr=%0d data=%h exp 1/5/deadbeef00000001",
                     wb_en, rd0_addr, rd0_data);
        else n_pass++;
        tick();
        n_total++;
        if (wb_en !== 1'b0) $display("FAIL single_alu_idle wb=%b exp=0", wb_en);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        alu_vld = 1; alu_rd = 3; alu_data = 64'h33;
        lsu_vld = 1; lsu_rd = 4; lsu_data = 64'h44;
        #1;
        n_total++;
        if ({alu_rdy, lsu_rdy} !== 2'b01)
            $display("FAIL simul_ready got=%b exp=01", {alu_rdy, lsu_rdy});
        else n_pass++;
        tick();
        lsu_vld = 0;
        n_total++;
        if ({wb_en, rd0_addr, rd0_data} !== {1'b1, 5'd4, 64'h44})
            $display("FAIL simul_lsu_first wb=%b addr=%0d data=%h exp 1/4/44", wb_en, rd0_addr, rd0_data);
        else n_pass++;
        #1;
        n_total++;
        if (alu_rdy !== 1'b1) $display("FAIL simul_alu_rdy got=%b exp=1", alu_rdy);
        else n_pass++;
        tick();
        alu_vld = 0;
        n_total++;
        if ({wb_en, rd0_addr, rd0_data} !== {1'b1, 5'd3, 64'h33})
            $display("FAIL simul_alu_second wb=%b addr=%0d data=%h exp 1/3/33", wb_en, rd0_addr, rd0_data);
        else n_pass++;
        tick();
    endtask

    task automatic test_starvation();
        logic [4:0] exp_addr;
        alu_vld = 1; alu_rd = 20; alu_data = 64'hA1;
        lsu_vld = 1;
        for (int i = 0; i < SM + 2; i++) begin
            lsu_rd = 5'(10 + i); lsu_data = 64'(100 + i);
            #1;
            n_total++;
            if ({alu_rdy, lsu_rdy} !== ((i == SM) ? 2'b10 : 2'b01))
                $display("FAIL starve_ready cyc%0d got=%b exp=%b", i + 1, {alu_rdy, lsu_rdy},
                         (i == SM) ? 2'b10 : 2'b01);
            else n_pass++;
            exp_addr = (i == SM) ? 5'd20 : 5'(10 + i);
            tick();
            if (i == SM) alu_vld = 0;
            n_total++;
            if ({wb_en, rd0_addr} !== {1'b1, exp_addr})
                $display("FAIL starve_write cyc%0d wb=%b addr=%0d exp 1/%0d", i + 1, wb_en, rd0_addr, exp_addr);
            else n_pass++;
        end
        idle();
        tick();
    endtask

    task automatic test_scoreboard();
        iss_vld = 1; iss_rd = 7;
        tick();
        iss_vld = 0;
        n_total++;
        if (busy_vec[7] !== 1'b1) $display("FAIL sb_set got=%b exp=1", busy_vec[7]);
        else n_pass++;
        tick();
        alu_vld = 1; alu_rd = 7; alu_data = 64'h77;
        tick();
        alu_vld = 0;
        n_total++;
        if ({wb_en, rd0_addr, busy_vec[7]} !== {1'b1, 5'd7, 1'b1})
            $display("FAIL sb_wb_cycle wb=%b addr=%0d busy7=%b exp 1/7/1", wb_en, rd0_addr, busy_vec[7]);
        else n_pass++;
        iss_vld = 1; iss_rd = 7;     // re-issue while x7 is being written
        tick();
        iss_vld = 0;
        n_total++;
        if (busy_vec[7] !== 1'b1) $display("FAIL sb_set_wins got=%b exp=1", busy_vec[7]);
        else n_pass++;
        alu_vld = 1; alu_rd = 7;
        tick();
        alu_vld = 0;
        tick();
        n_total++;
        if (busy_vec !== 32'd0) $display("FAIL sb_clear got=%h exp=0", busy_vec);
        else n_pass++;
        iss_vld = 1; iss_rd = 0;
        tick();
        iss_vld = 0;
        n_total++;
        if (busy_vec !== 32'd0) $display("FAIL sb_x0_issue got=%h exp=0", busy_vec);
        else n_pass++;
    endtask

    task automatic test_x0_and_reset();
        lsu_vld = 1; lsu_rd = 0; lsu_data = 64'hBAD;
        #1;
        n_total++;
        if (lsu_rdy !== 1'b1) $display("FAIL x0_accept got=%b exp=1", lsu_rdy);
        else n_pass++;
        tick();
        lsu_vld = 0;
        n_total++;
        if (wb_en !== 1'b0) $display("FAIL x0_no_write wb=%b exp=0", wb_en);
        else n_pass++;
        iss_vld = 1; iss_rd = 9;
        tick();
        iss_vld = 0;
        lsu_vld = 1; lsu_rd = 9; lsu_data = 64'h99;
        tick();
        lsu_vld = 0;
        n_total++;
        if ({wb_en, busy_vec[9]} !== 2'b11)
            $display("FAIL midrst_pending wb=%b busy9=%b exp 1/1", wb_en, busy_vec[9]);
        else n_pass++;
        rst = 1;
        tick();
        rst = 0;
        n_total++;
        if ({wb_en, busy_vec} !== 33'd0)
            $display("FAIL midrst_drop wb=%b busy=%h exp 0/0", wb_en, busy_vec);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst      = ($urandom_range(0, 49) == 0);
            alu_vld  = $urandom_range(0, 1);
            lsu_vld  = ($urandom_range(0, 3) != 0);
            iss_vld  = $urandom_range(0, 1);
            alu_rd   = 5'($urandom_range(0, 31));
            lsu_rd   = 5'($urandom_range(0, 31));
            iss_rd   = 5'($urandom_range(0, 31));
            alu_data = {$urandom, $urandom};
            lsu_data = {$urandom, $urandom};
            #1;
            n_total++;
            if ({alu_rdy, lsu_rdy} !== model_ready())
                $display("FAIL rand_ready cyc%0d got=%b exp=%b", c, {alu_rdy, lsu_rdy}, model_ready());
            else n_pass++;
            tick();
            n_total++;
            if ({wb_en, rd0_addr, rd0_data, busy_vec} !== {m_wb, m_addr, m_data, m_busy})
                $display("FAIL rand_state cyc%0d got wb=%b addr=%0d data=%h busy=%h exp wb=%b addr=%0d data=%h busy=%h",
                         c, wb_en, rd0_addr, rd0_data, busy_vec, m_wb, m_addr, m_data, m_busy);
            else n_pass++;
        end
        rst = 0;
        idle();
    endtask

    initial begin
        rst = 1;
        idle();
        m_wait = 0; m_wb = 0; m_addr = 0; m_data = 0; m_busy = 0;
        @(negedge clk);
        test_reset();
        test_single_alu();
        test_simultaneous();
        test_starvation();
        test_scoreboard();
        test_x0_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
